// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// Parametrised VGA timing generator with four frame-synchronous test patterns.
// A clock divider produces the pixel tick. Position, sync, data-enable and colour
// are all computed from the *next* position and registered on the tick edge. The
// registered outputs therefore always agree with the registered hcount/vcount.
module vga_pattern_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter int   CLK_DIV   = 4,
    parameter int   COLOR_W   = 4,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    parameter int   V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    parameter int   HC_W      = $clog2(H_TOTAL),
    parameter int   VC_W      = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic [HC_W-1:0]    hcount,
    output logic [VC_W-1:0]    vcount,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    // Divider width: at least one bit, even when every clk is a pixel.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0]   DIV_ZERO   = DIV_W'(0);

    localparam logic [HC_W-1:0]    H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0]    HC_ONE     = HC_W'(1);
    localparam logic [HC_W-1:0]    HC_ZERO    = HC_W'(0);
    localparam logic [HC_W-1:0]    BAR_W      = HC_W'(H_ACTIVE / 8);
    localparam logic [HC_W-1:0]    BOX_LAST   = HC_W'(H_ACTIVE - 16);

    // One extra bit on the boundary constants so that an end value equal
    // to 2**HC_W (or 2**VC_W) still compares correctly.
    localparam logic [HC_W:0]      H_ACT_X    = (HC_W+1)'(H_ACTIVE);
    localparam logic [HC_W:0]      HS_BEG_X   = (HC_W+1)'(H_ACTIVE + H_FP);
    localparam logic [HC_W:0]      HS_END_X   = (HC_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HC_W:0]      BOX_SIZE_X = (HC_W+1)'(16);

    localparam logic [VC_W-1:0]    V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0]    VC_ONE     = VC_W'(1);
    localparam logic [VC_W-1:0]    VC_ZERO    = VC_W'(0);
    localparam logic [VC_W:0]      V_ACT_X    = (VC_W+1)'(V_ACTIVE);
    localparam logic [VC_W:0]      VS_BEG_X   = (VC_W+1)'(V_ACTIVE + V_FP);
    localparam logic [VC_W:0]      VS_END_X   = (VC_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VC_W:0]      BOX_TOP_X  = (VC_W+1)'(V_ACTIVE / 2 - 8);
    localparam logic [VC_W:0]      BOX_BOT_X  = (VC_W+1)'(V_ACTIVE / 2 + 8);

    localparam logic [COLOR_W-1:0] C_FULL     = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] C_ZERO     = {COLOR_W{1'b0}};

    // Pixel divider and tick
    logic [DIV_W-1:0]   div_r;
    logic [DIV_W-1:0]   div_nx_s;
    logic               tick_s;

    // Next position
    logic               h_wrap_s;
    logic               v_wrap_s;
    logic [HC_W-1:0]    h_nx_s;
    logic [VC_W-1:0]    v_nx_s;
    logic               fs_s;

    // Frame-synchronous state
    logic [1:0]         mode_q_r;
    logic [1:0]         mode_nx_s;
    logic [HC_W-1:0]    box_x_r;
    logic [HC_W-1:0]    box_nx_s;

    // Next registered outputs
    logic               hs_act_s;
    logic               vs_act_s;
    logic               hs_nx_s;
    logic               vs_nx_s;
    logic               de_nx_s;

    // Pattern helpers
    logic [2:0]         bar_s;
    logic [COLOR_W-1:0] grey_s;
    logic               checker_s;
    logic [HC_W:0]      box_end_x_s;
    logic               box_hit_s;
    logic [COLOR_W-1:0] r_nx_s;
    logic [COLOR_W-1:0] g_nx_s;
    logic [COLOR_W-1:0] b_nx_s;

    // Pixel tick: fires on the last divider count, then the divider restarts
    always_comb begin
        tick_s   = (div_r == DIV_LAST);
        div_nx_s = DIV_ZERO;
        if (tick_s) begin
            div_nx_s = DIV_ZERO;
        end else begin
            div_nx_s = div_r + DIV_ONE;
        end
    end

    // Next raster position; it moves only on a tick, line then frame wrap
    always_comb begin
        h_wrap_s = (hcount == H_LAST);
        v_wrap_s = (vcount == V_LAST);
        h_nx_s   = hcount;
        v_nx_s   = vcount;
        if (tick_s) begin
            if (h_wrap_s) begin
                h_nx_s = HC_ZERO;
                if (v_wrap_s) begin
                    v_nx_s = VC_ZERO;
                end else begin
                    v_nx_s = vcount + VC_ONE;
                end
            end else begin
                h_nx_s = hcount + HC_ONE;
            end
        end else begin
            h_nx_s = hcount;
            v_nx_s = vcount;
        end
        fs_s = tick_s && h_wrap_s && v_wrap_s;
    end

    // Frame-synchronous pattern select and box position seen by the new pixel
    always_comb begin
        mode_nx_s = mode_q_r;
        box_nx_s  = box_x_r;
        if (fs_s) begin
            mode_nx_s = mode;
            if (box_x_r == BOX_LAST) begin
                box_nx_s = HC_ZERO;
            end else begin
                box_nx_s = box_x_r + HC_ONE;
            end
        end else begin
            mode_nx_s = mode_q_r;
            box_nx_s  = box_x_r;
        end
    end

    // Sync pulses and data-enable for the next position
    always_comb begin
        hs_act_s = ({1'b0, h_nx_s} >= HS_BEG_X) && ({1'b0, h_nx_s} < HS_END_X);
        vs_act_s = ({1'b0, v_nx_s} >= VS_BEG_X) && ({1'b0, v_nx_s} < VS_END_X);
        de_nx_s  = ({1'b0, h_nx_s} < H_ACT_X) && ({1'b0, v_nx_s} < V_ACT_X);
        hs_nx_s  = ~HSYNC_POL;
        vs_nx_s  = ~VSYNC_POL;
        if (hs_act_s) begin
            hs_nx_s = HSYNC_POL;
        end else begin
            hs_nx_s = ~HSYNC_POL;
        end
        if (vs_act_s) begin
            vs_nx_s = VSYNC_POL;
        end else begin
            vs_nx_s = ~VSYNC_POL;
        end
    end

    // Test-pattern colour for the next position; black outside the active area
    always_comb begin
        bar_s       = 3'(h_nx_s / BAR_W);
        grey_s      = h_nx_s[COLOR_W+1:2];
        checker_s   = h_nx_s[5] ^ v_nx_s[5];
        box_end_x_s = {1'b0, box_nx_s} + BOX_SIZE_X;
        box_hit_s   = (h_nx_s >= box_nx_s) && ({1'b0, h_nx_s} < box_end_x_s) &&
                      ({1'b0, v_nx_s} >= BOX_TOP_X) && ({1'b0, v_nx_s} < BOX_BOT_X);
        r_nx_s      = C_ZERO;
        g_nx_s      = C_ZERO;
        b_nx_s      = C_ZERO;
        if (de_nx_s) begin
            case (mode_nx_s)
                2'd0: begin
                    r_nx_s = {COLOR_W{bar_s[2]}};
                    g_nx_s = {COLOR_W{bar_s[1]}};
                    b_nx_s = {COLOR_W{bar_s[0]}};
                end
                2'd1: begin
                    if (checker_s) begin
                        r_nx_s = C_FULL;
                        g_nx_s = C_FULL;
                        b_nx_s = C_FULL;
                    end else begin
                        r_nx_s = C_ZERO;
                        g_nx_s = C_ZERO;
                        b_nx_s = C_ZERO;
                    end
                end
                2'd2: begin
                    r_nx_s = grey_s;
                    g_nx_s = grey_s;
                    b_nx_s = grey_s;
                end
                2'd3: begin
                    if (box_hit_s) begin
                        r_nx_s = C_FULL;
                        g_nx_s = C_FULL;
                        b_nx_s = C_FULL;
                    end else begin
                        r_nx_s = C_ZERO;
                        g_nx_s = C_ZERO;
                        b_nx_s = C_ZERO;
                    end
                end
                default: begin
                    r_nx_s = C_ZERO;
                    g_nx_s = C_ZERO;
                    b_nx_s = C_ZERO;
                end
            endcase
        end else begin
            r_nx_s = C_ZERO;
            g_nx_s = C_ZERO;
            b_nx_s = C_ZERO;
        end
    end

    // Divider register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_r <= DIV_ZERO;
        end else begin
            div_r <= div_nx_s;
        end
    end

    // Position, sync and colour outputs; they change together on each pixel tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount <= H_LAST;
            vcount <= V_LAST;
            hsync  <= ~HSYNC_POL;
            vsync  <= ~VSYNC_POL;
            de     <= 1'b0;
            red    <= C_ZERO;
            green  <= C_ZERO;
            blue   <= C_ZERO;
        end else if (tick_s) begin
            hcount <= h_nx_s;
            vcount <= v_nx_s;
            hsync  <= hs_nx_s;
            vsync  <= vs_nx_s;
            de     <= de_nx_s;
            red    <= r_nx_s;
            green  <= g_nx_s;
            blue   <= b_nx_s;
        end
    end

    // Frame-start pulse, frame counter and the state latched at each frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
            mode_q_r    <= 2'd0;
            box_x_r     <= HC_ZERO;
        end else begin
            frame_start <= fs_s;
            mode_q_r    <= mode_nx_s;
            box_x_r     <= box_nx_s;
            if (fs_s) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen
// Two instances run side by side. dut0 uses the default 640x480 timing and is
// watched over its first lines. dut1 is a small raster with CLK_DIV=1 and
// active-high syncs, run over many frames. For each instance, a closed-form
// reference computes the expected outputs from the number of clocks since reset
// and the mode the bench drove at each frame start. The expected results are
// queued at the clock edge and compared on the following falling edge.
module tb_vga_pattern_gen;

    localparam int S_HA = 32;
    localparam int S_HF = 2;
    localparam int S_HS = 4;
    localparam int S_HB = 2;
    localparam int S_VA = 40;
    localparam int S_VF = 1;
    localparam int S_VS = 2;
    localparam int S_VB = 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;

    logic       hs0, vs0, de0, fs0;
    logic [3:0] r0, g0, b0;
    logic [9:0] hc0, vc0;
    logic [7:0] fc0;

    logic       hs1, vs1, de1, fs1;
    logic [3:0] r1, g1, b1;
    logic [5:0] hc1, vc1;
    logic [7:0] fc1;

    int checks   = 0;
    int failures = 0;

    int k  [2];
    int mq [2];
    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q1 [$];
    logic [63:0] e0, e1;
    int hs_lo0 = 0, de_hi0 = 0, hs_hi1 = 0, de_hi1 = 0;

    vga_pattern_gen dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .hsync(hs0), .vsync(vs0), .de(de0),
        .red(r0), .green(g0), .blue(b0),
        .hcount(hc0), .vcount(vc0),
        .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_pattern_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .CLK_DIV(1), .COLOR_W(4), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .hsync(hs1), .vsync(vs1), .de(de1),
        .red(r1), .green(g1), .blue(b1),
        .hcount(hc1), .vcount(vc1),
        .frame_start(fs1), .frame_cnt(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic hs, input logic vs, input logic de,
                                         input int r, input int g, input int b,
                                         input int h, input int v, input logic fs, input int fc);
        logic [3:0] r4, g4, b4;
        logic [9:0] h10, v10;
        logic [7:0] fc8;
        r4 = 4'(r); g4 = 4'(g); b4 = 4'(b);
        h10 = 10'(h); v10 = 10'(v); fc8 = 8'(fc);
        return 64'({hs, vs, de, r4, g4, b4, h10, v10, fs, fc8});
    endfunction

    // Reference: position is a function of the tick count since reset
    task automatic model_step(input int d, output logic [63:0] e);
        int ha, hf, hw, hb, va, vf, vw, vb, dv, htot, vtot;
        int n, l, h, v, f, box, r, g, b, i;
        logic hp, vp, hs, vs, de, fs;
        if (d == 0) begin
            ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33;
            dv = 4; hp = 1'b0; vp = 1'b0;
        end else begin
            ha = S_HA; hf = S_HF; hw = S_HS; hb = S_HB; va = S_VA; vf = S_VF; vw = S_VS; vb = S_VB;
            dv = 1; hp = 1'b1; vp = 1'b1;
        end
        htot = ha + hf + hw + hb;
        vtot = va + vf + vw + vb;
        if (!rst_n) begin
            k[d]  = 0;
            mq[d] = 0;
        end else begin
            k[d] = k[d] + 1;
        end
        n = k[d] / dv;
        if (n == 0) begin
            e = pack(~hp, ~vp, 1'b0, 0, 0, 0, htot - 1, vtot - 1, 1'b0, 0);
        end else begin
            l   = n - 1;
            h   = l % htot;
            v   = (l / htot) % vtot;
            f   = l / (htot * vtot);
            fs  = (k[d] % dv == 0) && (h == 0) && (v == 0);
            if (fs) mq[d] = int'(mode);
            box = (f + 1) % (ha - 15);
            hs  = (h >= ha + hf && h < ha + hf + hw) ? hp : ~hp;
            vs  = (v >= va + vf && v < va + vf + vw) ? vp : ~vp;
            de  = (h < ha) && (v < va);
            r = 0; g = 0; b = 0;
            if (de) begin
                case (mq[d])
                    0: begin
                        i = h / (ha / 8);
                        r = ((i & 4) != 0) ? 15 : 0;
                        g = ((i & 2) != 0) ? 15 : 0;
                        b = ((i & 1) != 0) ? 15 : 0;
                    end
                    1: begin
                        if (((h / 32) % 2) != ((v / 32) % 2)) begin r = 15; g = 15; b = 15; end
                    end
                    2: begin
                        r = (h / 4) % 16; g = r; b = r;
                    end
                    3: begin
                        if (h >= box && h < box + 16 && v >= va / 2 - 8 && v < va / 2 + 8) begin
                            r = 15; g = 15; b = 15;
                        end
                    end
                    default: begin r = 0; g = 0; b = 0; end
                endcase
            end
            e = pack(hs, vs, de, r, g, b, h, v, fs, (f + 1) % 256);
        end
    endtask

    // Push the expected outputs for this edge
    always @(posedge clk) begin
        model_step(0, e0);
        exp_q0.push_back(e0);
        model_step(1, e1);
        exp_q1.push_back(e1);
    end

    // Compare DUT outputs against the queued expectation; accumulate line-0 widths
    always @(negedge clk) begin
        if (exp_q0.size() != 0)
            check_val("dut0_outputs", 64'({hs0, vs0, de0, r0, g0, b0, hc0, vc0, fs0, fc0}),
                      exp_q0.pop_front());
        if (exp_q1.size() != 0)
            check_val("dut1_outputs", 64'({hs1, vs1, de1, r1, g1, b1, 10'(hc1), 10'(vc1), fs1, fc1}),
                      exp_q1.pop_front());
        if (k[0] >= 4 && k[0] <= 3203) begin
            if (hs0 == 1'b0) hs_lo0 = hs_lo0 + 1;
            if (de0) de_hi0 = de_hi0 + 1;
        end
        if (k[1] >= 1 && k[1] <= 40) begin
            if (hs1 == 1'b1) hs_hi1 = hs_hi1 + 1;
            if (de1) de_hi1 = de_hi1 + 1;
        end
    end

    initial begin
        rst_n = 1'b0;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3300) @(negedge clk);
        check_val("dut0_hsync_low_clks_line0", 64'(hs_lo0), 64'd384);
        check_val("dut0_de_high_clks_line0", 64'(de_hi0), 64'd2560);
        check_val("dut1_hsync_high_clks_line0", 64'(hs_hi1), 64'd4);
        check_val("dut1_de_high_clks_line0", 64'(de_hi1), 64'd32);
        // mid-frame mode changes: visible only from the next frame start
        mode = 2'd1;
        repeat (1000) @(negedge clk);
        mode = 2'd2;
        repeat (2500) @(negedge clk);
        mode = 2'd3;
        repeat (31990) @(negedge clk);
        // one-clock reset in the middle of an active line
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4000) @(negedge clk);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
